timer_peripheral: RTL and testbench

- Memory-mapped down-counting timer that sits on the CPU peripheral bus as a bus responder: it decodes addr/wr_en/rd_en from the core, returns read data and drives the core's irq input.
- It provides the periodic and one-shot interrupt source for the interrupt-vector path at PROM address 0x4.
- Its read data is zero when the block is not selected, so several peripherals can be OR-combined onto the core's data input.

---
 rtl/timer_peripheral.sv | 98 +++++++++
 tb/tb_timer_peripheral.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_peripheral.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and a level IRQ.
// Four byte registers at BASE_ADDR..BASE_ADDR+3: CTRL, COUNT, RELOAD, STATUS.
module timer_peripheral #(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic       clk_ip,
  input  logic       reset_ip,
  input  logic [7:0] addr_ip,
  input  logic [7:0] wr_data_ip,
  input  logic       wr_en_ip,
  input  logic       rd_en_ip,
  output logic [7:0] rd_data_op,
  output logic       irq_op
);

  typedef struct packed {
    logic [2:0] ps;
    logic       irq_en;
    logic       auto_reload;
    logic       en;
  } ctrl_t;

  ctrl_t      ctrl;
  logic [7:0] count;
  logic [7:0] reload;
  logic [7:0] prescaler;
  logic       ovf;

  logic       sel;
  logic [1:0] off;
  logic       wr_ctrl, wr_count, wr_reload, wr_status;
  logic       tick;
  logic       ovf_set;

  // 9-bit compare so a BASE_ADDR near 8'hFF never wraps into low addresses
  assign sel = ({1'b0, addr_ip} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, addr_ip} <= ({1'b0, BASE_ADDR} + 9'd3));
  assign off = addr_ip[1:0] - BASE_ADDR[1:0];

  assign wr_ctrl   = wr_en_ip && sel && (off == 2'd0);
  assign wr_count  = wr_en_ip && sel && (off == 2'd1);
  assign wr_reload = wr_en_ip && sel && (off == 2'd2);
  assign wr_status = wr_en_ip && sel && (off == 2'd3);

  assign tick    = ctrl.en && (prescaler == ((8'd1 << ctrl.ps) - 8'd1));
  assign ovf_set = tick && (count == 8'd0);

  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      ctrl      <= '0;
      count     <= 8'd0;
      reload    <= 8'd0;
      prescaler <= 8'd0;
      ovf       <= 1'b0;
    end else begin
      prescaler <= (wr_ctrl || !ctrl.en || tick) ? 8'd0 : prescaler + 8'd1;

      // Clear first so a same-edge overflow set takes precedence
      if (wr_status && wr_data_ip[0])
        ovf <= 1'b0;

      if (tick) begin
        if (count != 8'd0)
          count <= count - 8'd1;
        else if (ctrl.auto_reload)
          count <= reload;
        else
          ctrl.en <= 1'b0;
      end
      if (ovf_set)
        ovf <= 1'b1;

      // Bus writes land last so they win over tick-side updates
      if (wr_ctrl)
        ctrl <= wr_data_ip[5:0];
      if (wr_count)
        count <= wr_data_ip;
      if (wr_reload)
        reload <= wr_data_ip;
    end
  end

  always_comb begin
    rd_data_op = 8'h00;
    if (rd_en_ip && sel) begin
      case (off)
        2'd0: rd_data_op = {2'b00, ctrl};
        2'd1: rd_data_op = count;
        2'd2: rd_data_op = reload;
        2'd3: rd_data_op = {7'd0, ovf};
        default: rd_data_op = 8'h00;
      endcase
    end
  end

  assign irq_op = ovf & ctrl.irq_en;

endmodule

// File: tb/tb_timer_peripheral.sv
// Scoreboard bench for timer_peripheral: expectations queued with stimulus, popped on sample.
module tb_timer_peripheral;

  localparam logic [7:0] B = 8'h10;

  logic       clk = 1'b0;
  logic       reset_ip = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       irq;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] got;

  timer_peripheral #(.BASE_ADDR(B)) dut (
    .clk_ip    (clk),
    .reset_ip  (reset_ip),
    .addr_ip   (addr),
    .wr_data_ip(wr_data),
    .wr_en_ip  (wr_en),
    .rd_en_ip  (rd_en),
    .rd_data_op(rd_data),
    .irq_op    (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; addr = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    #1;
    d = rd_data;
    rd_en = 1'b0; addr = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ip = 1'b1;
    @(negedge clk);
    reset_ip = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] a;
    do_reset();
    bus_write(B + 8'd2, 8'd5);
    bus_write(B + 8'd1, 8'd0);
    bus_write(B, 8'h07);
    @(posedge clk); #1;
    exp_q.push_back('{"rst_pre_irq", 8'h01});
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    exp_q.push_back('{"rst_pre_count", 8'd5});
    bus_read(B + 8'd1, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    // async reset between edges while a read is in progress
    addr = B + 8'd1; rd_en = 1'b1;
    #1;
    exp_q.push_back('{"rst_async_rd", 8'h00});
    exp_q.push_back('{"rst_async_irq", 8'h00});
    reset_ip = 1'b1;
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (rd_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data, e.val); end
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    rd_en = 1'b0; addr = 8'h00;
    @(negedge clk);
    reset_ip = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{$sformatf("rst_reg%0d", i), 8'h00});
    for (int i = 0; i < 4; i++) begin
      a = B + 8'(i);
      bus_read(a, got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] want_irq [4] = '{8'h00, 8'h01, 8'h00, 8'h01};
    do_reset();
    bus_write(B + 8'd2, 8'd3);
    bus_write(B + 8'd1, 8'd3);
    bus_write(B, 8'h07);                         // E0
    for (int i = 0; i < 2; i++) exp_q.push_back('{$sformatf("ar_irq_e%0d", 3 + i), want_irq[i]});
    repeat (3) @(posedge clk);
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    @(posedge clk); #1;                          // E4: first overflow
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    exp_q.push_back('{"ar_irq_clr", 8'h00});
    bus_write(B + 8'd3, 8'h01);                  // E5
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    for (int i = 2; i < 4; i++) exp_q.push_back('{$sformatf("ar_irq_e%0d", 5 + i), want_irq[i]});
    repeat (2) @(posedge clk);
    #1;                                          // E7
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    @(posedge clk); #1;                          // E8: second overflow
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    exp_q.push_back('{"ar_count_reloaded", 8'd3});
    bus_read(B + 8'd1, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
  endtask

  task automatic test_oneshot();
    logic [7:0] a;
    do_reset();
    bus_write(B + 8'd1, 8'd2);
    bus_write(B, 8'h15);                         // E0, PS=2
    exp_q.push_back('{"os_irq_e11", 8'h00});
    exp_q.push_back('{"os_irq_e12", 8'h01});
    repeat (11) @(posedge clk);
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    @(posedge clk); #1;
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    exp_q.push_back('{"os_ctrl", 8'h14});
    exp_q.push_back('{"os_count", 8'h00});
    exp_q.push_back('{"os_status", 8'h01});
    for (int i = 0; i < 4; i++) begin
      if (i == 2) continue;
      a = B + 8'(i);
      bus_read(a, got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    end
    repeat (20) @(posedge clk);
    exp_q.push_back('{"os_count_hold", 8'h00});
    bus_read(B + 8'd1, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
  endtask

  task automatic test_decode();
    logic [7:0] outside [3];
    logic [7:0] a;
    outside[0] = B - 8'd1; outside[1] = B + 8'd4; outside[2] = 8'h03;
    do_reset();
    bus_write(B + 8'd2, 8'h55);
    for (int i = 0; i < 3; i++) bus_write(outside[i], 8'hAA);
    for (int i = 0; i < 3; i++) exp_q.push_back('{$sformatf("dec_out_rd%0d", i), 8'h00});
    for (int i = 0; i < 3; i++) begin
      bus_read(outside[i], got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    end
    exp_q.push_back('{"dec_ctrl", 8'h00});
    exp_q.push_back('{"dec_count", 8'h00});
    exp_q.push_back('{"dec_reload", 8'h55});
    exp_q.push_back('{"dec_status", 8'h00});
    for (int i = 0; i < 4; i++) begin
      a = B + 8'(i);
      bus_read(a, got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    end
    bus_write(B + 8'd1, 8'h07);
    exp_q.push_back('{"dec_no_rd_en", 8'h00});
    @(negedge clk);
    addr = B + 8'd1; rd_en = 1'b0;
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (rd_data !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data, e.val); end
    addr = 8'h00;
  endtask

  task automatic test_collisions();
    // COUNT write on a tick edge (PS=0 ticks every clock)
    do_reset();
    bus_write(B + 8'd1, 8'd5);
    bus_write(B, 8'h01);
    bus_write(B + 8'd1, 8'h09);
    exp_q.push_back('{"col_count_wr", 8'h09});
    bus_read(B + 8'd1, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    @(posedge clk);
    exp_q.push_back('{"col_count_dec", 8'h08});
    bus_read(B + 8'd1, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    // STATUS clear on the edge where OVF sets
    do_reset();
    bus_write(B + 8'd1, 8'd1);
    bus_write(B, 8'h01);                         // E0
    @(posedge clk);                              // E1
    bus_write(B + 8'd3, 8'h01);                  // E2: overflow edge
    exp_q.push_back('{"col_ovf_set_wins", 8'h01});
    exp_q.push_back('{"col_oneshot_ctrl", 8'h00});
    bus_read(B + 8'd3, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    bus_read(B, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    // CTRL write on the one-shot completion edge
    do_reset();
    bus_write(B + 8'd1, 8'd1);
    bus_write(B, 8'h01);
    @(posedge clk);
    bus_write(B, 8'h01);
    exp_q.push_back('{"col_ctrl_wins", 8'h01});
    bus_read(B, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    // RELOAD write on the reload edge: COUNT takes the old RELOAD
    do_reset();
    bus_write(B + 8'd2, 8'd6);
    bus_write(B + 8'd1, 8'd0);
    bus_write(B, 8'h03);                         // E0
    bus_write(B + 8'd2, 8'd2);                   // E1: reload edge
    exp_q.push_back('{"col_reload_old", 8'd6});
    exp_q.push_back('{"col_reload_new", 8'd2});
    bus_read(B + 8'd1, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    bus_read(B + 8'd2, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
  endtask

  task automatic test_irq_gating();
    do_reset();
    bus_write(B + 8'd1, 8'd0);
    bus_write(B, 8'h01);                         // E0
    @(posedge clk); #1;                          // E1: OVF set, IRQ_EN=0
    exp_q.push_back('{"gate_irq_off", 8'h00});
    exp_q.push_back('{"gate_ovf", 8'h01});
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    bus_read(B + 8'd3, got);
    e = exp_q.pop_front(); n_chk++;
    if (got !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, got, e.val); end
    exp_q.push_back('{"gate_pre_edge", 8'h00});
    exp_q.push_back('{"gate_post_edge", 8'h01});
    @(negedge clk);
    addr = B; wr_data = 8'h04; wr_en = 1'b1;
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    @(posedge clk); #1;
    wr_en = 1'b0; addr = 8'h00;
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    exp_q.push_back('{"gate_wr0_noclr", 8'h01});
    bus_write(B + 8'd3, 8'h00);
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
    exp_q.push_back('{"gate_wr1_clr", 8'h00});
    bus_write(B + 8'd3, 8'h01);
    e = exp_q.pop_front(); n_chk++;
    if ({7'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, irq, e.val); end
  endtask

  initial begin
    test_reset();
    test_auto_reload();
    test_oneshot();
    test_decode();
    test_collisions();
    test_irq_gating();
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
